sfifo_fwft_out_stage: RTL and testbench



---
 rtl/sfifo_fwft_out_stage.sv | 80 ++++++++
 tb/tb_sfifo_fwft_out_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sfifo_fwft_out_stage.sv
// First-word-fall-through output stage for the synchronous FIFO read controller.
// Turns request/empty reads (one-cycle read latency) into a valid/ready stream via head + skid.
module sfifo_fwft_out_stage #(
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 FIFOEmpty,
  input  logic [DataWidth-1:0] FIFORdData,
  output logic                 FIFORdReq,
  output logic [DataWidth-1:0] OutData,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [1:0]           Count
);

  logic [DataWidth-1:0] r_head_data, r_skid_data;
  logic                 r_head_valid, r_skid_valid;
  logic                 r_in_flight;

  logic [DataWidth-1:0] w_head_data, w_skid_data;
  logic                 w_head_valid, w_skid_valid;
  logic                 w_pop;
  logic [2:0]           w_occ;

  // The skid is only ever occupied behind a valid head, so occupancy is derived from the flags.
  assign Count    = {r_head_valid & r_skid_valid, r_head_valid ^ r_skid_valid};
  assign OutData  = r_head_data;
  assign OutValid = r_head_valid;

  assign w_pop = r_head_valid & OutReady;
  assign w_occ = {1'b0, Count} + {2'b00, r_in_flight} - {2'b00, w_pop};

  assign FIFORdReq = ~reset & ~FIFOEmpty & (w_occ <= 3'd1);

  always_comb begin
    w_head_data  = r_head_data;
    w_head_valid = r_head_valid;
    w_skid_data  = r_skid_data;
    w_skid_valid = r_skid_valid;
    if (r_in_flight) begin
      if (!r_head_valid || (w_pop && !r_skid_valid)) begin
        w_head_data  = FIFORdData;
        w_head_valid = 1'b1;
      end else if (w_pop) begin
        // Skid is older than the arriving word, so it advances first.
        w_head_data  = r_skid_data;
        w_skid_data  = FIFORdData;
        w_skid_valid = 1'b1;
      end else begin
        w_skid_data  = FIFORdData;
        w_skid_valid = 1'b1;
      end
    end else if (w_pop) begin
      if (r_skid_valid) begin
        w_head_data  = r_skid_data;
        w_skid_valid = 1'b0;
      end else begin
        w_head_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head_data  <= '0;
      r_head_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
      r_in_flight  <= 1'b0;
    end else begin
      r_head_data  <= w_head_data;
      r_head_valid <= w_head_valid;
      r_skid_data  <= w_skid_data;
      r_skid_valid <= w_skid_valid;
      r_in_flight  <= FIFORdReq;
    end
  end

endmodule

// File: tb/tb_sfifo_fwft_out_stage.sv
// Self-checking bench: queue-based FIFO and stage model checked every cycle, plus pinned
// literal expectations for latency, throughput, backpressure, shuffle and reset.
module tb_sfifo_fwft_out_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       FIFOEmpty;
  logic [7:0] FIFORdData;
  logic       FIFORdReq;
  logic [7:0] OutData;
  logic       OutValid;
  logic       OutReady;
  logic [1:0] Count;

  sfifo_fwft_out_stage #(.DataWidth(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .FIFOEmpty  (FIFOEmpty),
    .FIFORdData (FIFORdData),
    .FIFORdReq  (FIFORdReq),
    .OutData    (OutData),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .Count      (Count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] fifo_q[$];   // words still in the FIFO
  logic [7:0] held[$];     // words the stage should hold, oldest first
  logic [7:0] got[$];      // words the DUT actually handed over
  logic [7:0] exp_list[$];
  bit         inflight;
  logic [7:0] rd_word;
  int req_run, max_req_run, valid_run, max_valid_run, n_req;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic clear_stats();
    got.delete();
    exp_list.delete();
    req_run = 0; max_req_run = 0; valid_run = 0; max_valid_run = 0; n_req = 0;
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_list.push_back(w);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input bit rdy);
    bit pop, req;
    int occ;
    OutReady  = rdy;
    FIFOEmpty = (fifo_q.size() == 0);
    #1;
    pop = (held.size() != 0) && rdy;
    occ = held.size() + int'(inflight) - int'(pop);
    req = !FIFOEmpty && (occ <= 1);
    chk("out_valid", int'(OutValid), int'(held.size() != 0));
    chk("count", int'(Count), held.size());
    chk("rd_req", int'(FIFORdReq), int'(req));
    if (held.size() != 0) chk("out_data", int'(OutData), int'(held[0]));
    if (FIFOEmpty) chk("req_while_empty", int'(FIFORdReq), 0);
    if (Count > 2'd2) chk("count_le_2", int'(Count), 2);
    if (OutValid && rdy) got.push_back(OutData);
    if (FIFORdReq) n_req++;
    req_run   = FIFORdReq ? req_run + 1 : 0;
    valid_run = OutValid ? valid_run + 1 : 0;
    if (req_run > max_req_run) max_req_run = req_run;
    if (valid_run > max_valid_run) max_valid_run = valid_run;
    @(posedge clk);
    #1;
    if (pop) void'(held.pop_front());
    if (inflight) held.push_back(rd_word);
    inflight = req;
    if (req) begin
      rd_word    = fifo_q.pop_front();
      FIFORdData = rd_word;
    end else begin
      FIFORdData = 8'($urandom);
    end
    @(negedge clk);
  endtask

  task automatic check_got(input string name);
    chk({name, "_len"}, got.size(), exp_list.size());
    for (int i = 0; i < got.size() && i < exp_list.size(); i++)
      chk({name, "_word"}, int'(got[i]), int'(exp_list[i]));
  endtask

  initial begin
    reset = 1'b1; OutReady = 1'b1; FIFOEmpty = 1'b0; FIFORdData = 8'h00;
    inflight = 1'b0; rd_word = 8'h00;
    repeat (2) @(negedge clk);
    // FIFO reports data yet reset must suppress the request.
    chk("rst_req", int'(FIFORdReq), 0);
    chk("rst_valid", int'(OutValid), 0);
    chk("rst_count", int'(Count), 0);
    chk("rst_data", int'(OutData), 0);
    reset = 1'b0; FIFOEmpty = 1'b1;
    repeat (2) cycle(1'b1);

    // Single word
    clear_stats();
    push(8'hA5);
    cycle(1'b1);
    cycle(1'b1);
    chk("single_valid_n2", int'(OutValid), 1);
    chk("single_data_n2", int'(OutData), 8'hA5);
    cycle(1'b1);
    chk("single_valid_after", int'(OutValid), 0);
    chk("single_count_after", int'(Count), 0);
    repeat (3) cycle(1'b1);
    chk("single_req_pulses", n_req, 1);
    check_got("single");

    // Streaming 16 words at full rate
    clear_stats();
    for (int i = 0; i < 16; i++) push(8'(i));
    repeat (22) cycle(1'b1);
    chk("stream_req_run", max_req_run, 16);
    chk("stream_valid_run", max_valid_run, 16);
    check_got("stream");

    // Backpressure
    clear_stats();
    for (int i = 0; i < 5; i++) push(8'(i));
    repeat (6) cycle(1'b0);
    chk("bp_count", int'(Count), 2);
    chk("bp_data", int'(OutData), 8'h00);
    chk("bp_req", int'(FIFORdReq), 0);
    chk("bp_fifo_left", fifo_q.size(), 3);
    repeat (10) cycle(1'b1);
    check_got("bp");

    // Skid shuffle: full stage, pop every cycle
    clear_stats();
    for (int i = 0; i < 6; i++) push(8'h40 + 8'(i));
    repeat (5) cycle(1'b0);
    cycle(1'b1);
    chk("shuffle_head_from_skid", int'(OutData), 8'h41);
    chk("shuffle_count", int'(Count), 1);
    repeat (10) cycle(1'b1);
    check_got("shuffle");

    // Random backpressure and bursty FIFO fill, 200 words
    clear_stats();
    begin
      int sent = 0;
      int budget = 4000;
      while ((sent < 200 || fifo_q.size() != 0 || held.size() != 0 || inflight) && budget > 0) begin
        if (sent < 200 && ($urandom_range(0, 2) != 0)) begin
          push(8'($urandom));
          sent++;
        end
        cycle(1'($urandom_range(0, 1)));
        budget--;
      end
      chk("random_budget", int'(budget > 0), 1);
    end
    check_got("random");

    // Reset mid-burst
    clear_stats();
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    repeat (5) cycle(1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", int'(OutValid), 0);
    chk("mid_rst_count", int'(Count), 0);
    chk("mid_rst_req", int'(FIFORdReq), 0);
    fifo_q.delete(); held.delete(); inflight = 1'b0;
    @(negedge clk);
    reset = 1'b0; FIFOEmpty = 1'b1;
    clear_stats();
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
    repeat (14) cycle(1'b1);
    check_got("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
